// File: rtl/tinycpu_pkg.sv
// Shared encodings for the tinyCPU multi-cycle controller: opcodes, datapath
// control codes, sequencer states and the decoded-instruction context.
package tinycpu_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;

  localparam logic [5:0] EXT_R = 6'b000000;
  localparam logic [5:0] EXT_S = 6'b000001;
  localparam logic [5:0] EXT_I = 6'b000010;

  localparam logic [2:0] DMT_WORD   = 3'b000;
  localparam logic [2:0] DMT_HALF   = 3'b001;
  localparam logic [2:0] DMT_HALF_U = 3'b010;
  localparam logic [2:0] DMT_BYTE   = 3'b011;
  localparam logic [2:0] DMT_BYTE_U = 3'b100;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_LOAD, CLS_STORE} cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [4:0] alu_op;
    logic [5:0] ext_op;
    logic [2:0] dmt;
  } ctx_t;

  typedef struct packed {
    ctx_t ctx;
    logic illegal;
  } dec_t;

  // Only signed byte/half/word accesses are implemented.
  function automatic logic size_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  function automatic logic [2:0] size_dmt(input logic [2:0] f3);
    case (f3)
      3'b000:  return DMT_BYTE;
      3'b001:  return DMT_HALF;
      default: return DMT_WORD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-register fields, memory handshake and datapath controls between
// the multi-cycle sequencer (slave side) and the datapath/memory (master side).
interface multicycle_ctrl_if #(parameter int INSTRET_W = 32);
  logic [6:0]           Op;
  logic [2:0]           Funct3;
  logic [6:0]           Funct7;
  logic                 mem_ready;
  logic                 memReq;
  logic                 memWrite;
  logic                 memAddrSel;
  logic                 irWrite;
  logic                 pcWrite;
  logic                 regWrite;
  logic [4:0]           ALUOp;
  logic                 ALUSrc;
  logic [5:0]           EXTOp;
  logic [2:0]           dataMemoryType;
  logic                 writeDataSelection;
  logic                 illegal;
  logic                 bus_err;
  logic [2:0]           state;
  logic [INSTRET_W-1:0] instret;

  modport master (
    output Op, Funct3, Funct7, mem_ready,
    input  memReq, memWrite, memAddrSel, irWrite, pcWrite, regWrite, ALUOp, ALUSrc,
           EXTOp, dataMemoryType, writeDataSelection, illegal, bus_err, state, instret
  );

  modport slave (
    input  Op, Funct3, Funct7, mem_ready,
    output memReq, memWrite, memAddrSel, irWrite, pcWrite, regWrite, ALUOp, ALUSrc,
           EXTOp, dataMemoryType, writeDataSelection, illegal, bus_err, state, instret
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier; its result is captured by the
// sequencer only while in DECODE.
module ctrl_decode
  import tinycpu_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output dec_t       dec_o
);

  always_comb begin
    // NOTE: defaulting every field first keeps unmatched paths from inferring latches.
    dec_o         = '0;
    dec_o.illegal = 1'b1;
    case (op_i)
      OP_R: begin
        dec_o.ctx.cls = CLS_R;
        if (funct3_i == 3'b000 && funct7_i == 7'b0000000) begin
          dec_o.ctx.alu_op = ALU_ADD;
          dec_o.illegal    = 1'b0;
        end else if (funct3_i == 3'b000 && funct7_i == 7'b0100000) begin
          dec_o.ctx.alu_op = ALU_SUB;
          dec_o.illegal    = 1'b0;
        end
      end
      OP_I: begin
        dec_o.ctx.cls    = CLS_I;
        dec_o.ctx.alu_op = ALU_ADD;
        dec_o.ctx.ext_op = EXT_I;
        dec_o.illegal    = (funct3_i != 3'b000);
      end
      OP_LOAD: begin
        dec_o.ctx.cls    = CLS_LOAD;
        dec_o.ctx.alu_op = ALU_ADD;
        dec_o.ctx.ext_op = EXT_I;
        dec_o.ctx.dmt    = size_dmt(funct3_i);
        dec_o.illegal    = !size_ok(funct3_i);
      end
      OP_STORE: begin
        dec_o.ctx.cls    = CLS_STORE;
        dec_o.ctx.alu_op = ALU_ADD;
        dec_o.ctx.ext_op = EXT_S;
        dec_o.ctx.dmt    = size_dmt(funct3_i);
        dec_o.illegal    = !size_ok(funct3_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for tinyCPU sharing one memory port between fetch and
// data access; traps on illegal opcodes and memory timeouts, counts retirements.
module multicycle_ctrl
  import tinycpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input logic              clk,
  input logic              rstn,
  multicycle_ctrl_if.slave bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e               state_q, state_d;
  ctx_t                 ctx_q, ctx_d;
  dec_t                 dec;
  logic                 run_q;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_err_q, bus_err_d;
  logic                 mem_req, timeout;

  ctrl_decode u_decode (
    .op_i     (bus.Op),
    .funct3_i (bus.Funct3),
    .funct7_i (bus.Funct7),
    .dec_o    (dec)
  );

  // run_q holds off the first fetch until one clock edge after reset release.
  assign mem_req = (state_q == ST_FETCH && run_q) || (state_q == ST_MEM);
  assign timeout = (MEM_TIMEOUT > 0) && mem_req && !bus.mem_ready &&
                   (wait_q == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d   = state_q;
    ctx_d     = ctx_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    wait_d    = wait_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_req && bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end
      end
      ST_DECODE: begin
        ctx_d = dec.ctx;
        if (dec.illegal) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = (ctx_q.cls == CLS_LOAD || ctx_q.cls == CLS_STORE) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (bus.mem_ready) begin
          if (ctx_q.cls == CLS_STORE) begin
            state_d   = ST_FETCH;
            instret_d = instret_q + INSTRET_W'(1);
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end
      end
      ST_WB: begin
        state_d   = ST_FETCH;
        instret_d = instret_q + INSTRET_W'(1);
      end
      ST_TRAP: ;
      default: state_d = ST_TRAP;
    endcase

    // The wait count restarts whenever a new state (FETCH or MEM) is entered.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((MEM_TIMEOUT > 0) && mem_req && !bus.mem_ready &&
                 (wait_q != WAIT_W'(MEM_TIMEOUT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    bus.memReq             = mem_req;
    bus.memWrite           = 1'b0;
    bus.memAddrSel         = 1'b0;
    bus.irWrite            = 1'b0;
    bus.pcWrite            = 1'b0;
    bus.regWrite           = 1'b0;
    bus.ALUOp              = ALU_NOP;
    bus.ALUSrc             = 1'b0;
    bus.EXTOp              = EXT_R;
    bus.dataMemoryType     = DMT_WORD;
    bus.writeDataSelection = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.irWrite = mem_req && bus.mem_ready;
        bus.pcWrite = mem_req && bus.mem_ready;
      end
      ST_EXEC: begin
        bus.ALUOp  = ctx_q.alu_op;
        bus.ALUSrc = (ctx_q.cls != CLS_R);
        bus.EXTOp  = ctx_q.ext_op;
      end
      ST_MEM: begin
        bus.memAddrSel     = 1'b1;
        bus.memWrite       = (ctx_q.cls == CLS_STORE);
        bus.ALUOp          = ctx_q.alu_op;
        bus.ALUSrc         = 1'b1;
        bus.EXTOp          = ctx_q.ext_op;
        bus.dataMemoryType = ctx_q.dmt;
      end
      ST_WB: begin
        bus.regWrite           = 1'b1;
        bus.writeDataSelection = (ctx_q.cls == CLS_LOAD);
        bus.dataMemoryType     = ctx_q.dmt;
      end
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.state   = state_q;
  assign bus.instret = instret_q;

  // NOTE: non-blocking updates make every register see pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_FETCH;
      ctx_q     <= '0;
      run_q     <= 1'b0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctx_q     <= ctx_d;
      run_q     <= 1'b1;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: stimulus pushes per-cycle expected
// outputs into a scoreboard queue, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic        req, wr, asel, irw, pcw, rw, wds, ill, berr;
    logic [31:0] ir;
    logic [4:0]  aluop;
    logic        src;
    logic [5:0]  ext;
    logic [2:0]  dmt;
  } obs_t;

  typedef struct {
    obs_t       o;
    logic [3:0] care;  // aluop, src, ext, dmt
    string      nm;
  } exp_t;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  multicycle_ctrl_if #(.INSTRET_W(32)) bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(4), .INSTRET_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t a;
    a.st = bus.state;     a.req = bus.memReq;   a.wr = bus.memWrite;
    a.asel = bus.memAddrSel; a.irw = bus.irWrite; a.pcw = bus.pcWrite;
    a.rw = bus.regWrite;  a.wds = bus.writeDataSelection;
    a.ill = bus.illegal;  a.berr = bus.bus_err; a.ir = bus.instret;
    a.aluop = bus.ALUOp;  a.src = bus.ALUSrc;   a.ext = bus.EXTOp;
    a.dmt = bus.dataMemoryType;
    return a;
  endfunction

  function automatic obs_t masked(input obs_t v, input logic [3:0] care);
    obs_t m = v;
    if (!care[3]) m.aluop = '0;
    if (!care[2]) m.src   = 1'b0;
    if (!care[1]) m.ext   = '0;
    if (!care[0]) m.dmt   = '0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.nm, 64'(masked(sample(), e.care)), 64'(masked(e.o, e.care)));
    end
  end

  function automatic exp_t mk(input string nm, input logic [2:0] st, input logic [31:0] ir);
    exp_t e;
    e.o = '0; e.o.st = st; e.o.ir = ir; e.care = 4'b0000; e.nm = nm;
    return e;
  endfunction

  task automatic step(input logic rdy, input exp_t e);
    bus.mem_ready = rdy;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.Op = op; bus.Funct3 = f3; bus.Funct7 = f7;
  endtask

  task automatic s_fetch(input string nm, input logic [31:0] ir, input logic rdy);
    exp_t e = mk(nm, 3'd0, ir);
    e.o.req = 1'b1; e.o.irw = rdy; e.o.pcw = rdy;
    step(rdy, e);
  endtask

  task automatic s_exec(input string nm, input logic [31:0] ir, input logic [4:0] aluop,
                        input logic src, input logic [5:0] ext);
    exp_t e = mk(nm, 3'd2, ir);
    e.o.aluop = aluop; e.o.src = src; e.o.ext = ext; e.care = 4'b1110;
    step(1'b0, e);
  endtask

  task automatic s_mem(input string nm, input logic [31:0] ir, input logic wr, input logic [2:0] dmt,
                       input logic [5:0] ext, input logic ext_care, input logic rdy);
    exp_t e = mk(nm, 3'd3, ir);
    e.o.req = 1'b1; e.o.asel = 1'b1; e.o.wr = wr; e.o.dmt = dmt; e.o.ext = ext;
    e.care = {2'b00, ext_care, 1'b1};
    step(rdy, e);
  endtask

  task automatic s_wb(input string nm, input logic [31:0] ir, input logic wds);
    exp_t e = mk(nm, 3'd4, ir);
    e.o.rw = 1'b1; e.o.wds = wds;
    step(1'b1, e);
  endtask

  task automatic s_trap(input string nm, input logic [31:0] ir, input logic ill, input logic be);
    exp_t e = mk(nm, 3'd7, ir);
    e.o.ill = ill; e.o.berr = be;
    step(1'b1, e);
  endtask

  task automatic run_alu(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] ir, input logic [4:0] aluop,
                         input logic src, input logic [5:0] ext);
    set_instr(op, f3, f7);
    s_fetch({nm, "_fetch"}, ir, 1'b1);
    step(1'b1, mk({nm, "_dec"}, 3'd1, ir));
    s_exec({nm, "_exec"}, ir, aluop, src, ext);
    s_wb({nm, "_wb"}, ir, 1'b0);
  endtask

  // Async reset asserted mid-cycle: outputs must drop before any clock edge.
  task automatic do_reset(input string nm);
    rstn = 1'b0;
    #1;
    check({nm, "_async_state"}, 64'(bus.state), 64'd0);
    check({nm, "_async_memreq"}, 64'(bus.memReq), 64'd0);
    check({nm, "_async_instret"}, 64'(bus.instret), 64'd0);
    check({nm, "_async_flags"}, 64'({bus.illegal, bus.bus_err}), 64'd0);
    step(1'b0, mk({nm, "_hold"}, 3'd0, 32'd0));
    rstn = 1'b1;
    step(1'b0, mk({nm, "_idle"}, 3'd0, 32'd0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    bus.mem_ready = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0);
    @(posedge clk);
    #1;
    do_reset("por");

    run_alu("add",  7'b0110011, 3'b000, 7'b0000000, 32'd0, 5'b00011, 1'b0, 6'b000000);
    run_alu("sub",  7'b0110011, 3'b000, 7'b0100000, 32'd1, 5'b00100, 1'b0, 6'b000000);
    run_alu("addi", 7'b0010011, 3'b000, 7'b1010101, 32'd2, 5'b00011, 1'b1, 6'b000010);

    // lh with three wait cycles in MEM
    set_instr(7'b0000011, 3'b001, 7'd0);
    s_fetch("lh_fetch", 32'd3, 1'b1);
    step(1'b0, mk("lh_dec", 3'd1, 32'd3));
    s_exec("lh_exec", 32'd3, 5'b00011, 1'b1, 6'b000010);
    for (int i = 0; i < 3; i++) s_mem("lh_mem_wait", 32'd3, 1'b0, 3'b001, 6'd0, 1'b0, 1'b0);
    s_mem("lh_mem_done", 32'd3, 1'b0, 3'b001, 6'd0, 1'b0, 1'b1);
    s_wb("lh_wb", 32'd3, 1'b1);

    set_instr(7'b0100011, 3'b000, 7'd0);
    s_fetch("sb_fetch", 32'd4, 1'b1);
    step(1'b1, mk("sb_dec", 3'd1, 32'd4));
    s_exec("sb_exec", 32'd4, 5'b00011, 1'b1, 6'b000001);
    s_mem("sb_mem", 32'd4, 1'b1, 3'b011, 6'b000001, 1'b1, 1'b1);

    set_instr(7'b0000011, 3'b010, 7'd0);
    s_fetch("lw_fetch", 32'd5, 1'b1);
    step(1'b1, mk("lw_dec", 3'd1, 32'd5));
    s_exec("lw_exec", 32'd5, 5'b00011, 1'b1, 6'b000010);
    s_mem("lw_mem", 32'd5, 1'b0, 3'b000, 6'd0, 1'b0, 1'b1);
    s_wb("lw_wb", 32'd5, 1'b1);

    // Four wait cycles, then mem_ready as the count reaches the limit: no trap
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    for (int i = 0; i < 4; i++) s_fetch("to_edge_wait", 32'd6, 1'b0);
    s_fetch("to_edge_ready", 32'd6, 1'b1);
    step(1'b1, mk("to_edge_dec", 3'd1, 32'd6));
    s_exec("to_edge_exec", 32'd6, 5'b00011, 1'b0, 6'b000000);
    s_wb("to_edge_wb", 32'd6, 1'b0);

    // mem_ready still low once the count is at the limit: bus error trap
    for (int i = 0; i < 5; i++) s_fetch("to_wait", 32'd7, 1'b0);
    for (int i = 0; i < 3; i++) s_trap("to_trap", 32'd7, 1'b0, 1'b1);
    do_reset("rst_after_buserr");

    set_instr(7'b1111111, 3'b000, 7'd0);
    s_fetch("ill_fetch", 32'd0, 1'b1);
    step(1'b1, mk("ill_dec", 3'd1, 32'd0));
    for (int i = 0; i < 21; i++) s_trap("ill_trap", 32'd0, 1'b1, 1'b0);
    do_reset("rst_after_illegal");

    run_alu("pre", 7'b0110011, 3'b000, 7'b0000000, 32'd0, 5'b00011, 1'b0, 6'b000000);
    set_instr(7'b0000011, 3'b010, 7'd0);
    s_fetch("mid_fetch", 32'd1, 1'b1);
    step(1'b1, mk("mid_dec", 3'd1, 32'd1));
    s_exec("mid_exec", 32'd1, 5'b00011, 1'b1, 6'b000010);
    s_mem("mid_mem", 32'd1, 1'b0, 3'b000, 6'd0, 1'b0, 1'b0);
    check("mid_mem_memreq", 64'(bus.memReq), 64'd1);
    check("mid_mem_state", 64'(bus.state), 64'd3);
    do_reset("rst_mid_mem");

    run_alu("restart", 7'b0110011, 3'b000, 7'b0000000, 32'd0, 5'b00011, 1'b0, 6'b000000);
    s_fetch("restart_next", 32'd1, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
